// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, command/response bytes and
// default timing for a 50 MHz system clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] BREAK       = 8'hF0;

  // 100 us inhibit, 2 us request-to-send, 15 ms frame limit at 50 MHz
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_RTS_CYCLES     = 100;
  localparam int DEF_TIMEOUT_CYCLES = 750000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a one-cycle falling-edge
// strobe; shared by the host transmitter and the keyboard receiver.
module ps2_line_sync (
  input  logic CLK,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge CLK) begin
    if (reset) begin
      // NOTE: reset to the idle-high line level so leaving reset never fakes a falling edge.
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= line_in;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out one
// byte with odd parity and stop on device clocks, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  input  logic [7:0] iData,
  input  logic       iStart,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  localparam int CNT_W = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       tx_byte;
  logic             parity;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic unused_data_fall;
  logic frame_active;
  logic timed_out;

  ps2_line_sync u_clk_sync (
    .CLK     (CLK),
    .reset   (reset),
    .line_in (PS2_CLK_IN),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .CLK     (CLK),
    .reset   (reset),
    .line_in (PS2_DATA_IN),
    .level   (data_level),
    .fall    (unused_data_fall)
  );

  // The frame deadline covers everything after the clock line is released.
  assign frame_active = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign timed_out    = frame_active && (cnt == TO_LAST);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      tx_byte     <= '0;
      parity      <= 1'b0;
      PS2_CLK_OE  <= 1'b0;
      PS2_DATA_OE <= 1'b0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oErr        <= 1'b0;
    end else begin
      // NOTE: oDone defaults low every cycle, so it can only ever be a one-cycle pulse.
      oDone <= 1'b0;
      if (timed_out) begin
        PS2_CLK_OE  <= 1'b0;
        PS2_DATA_OE <= 1'b0;
        oErr        <= 1'b1;
        oDone       <= 1'b1;
        state       <= DONE;
      end else begin
        case (state)
          IDLE: if (iStart) begin
            tx_byte    <= iData;
            parity     <= odd_parity(iData);
            oErr       <= 1'b0;
            oBusy      <= 1'b1;
            PS2_CLK_OE <= 1'b1;
            cnt        <= '0;
            state      <= INHIBIT;
          end
          INHIBIT: if (cnt == INH_LAST) begin
            cnt         <= '0;
            PS2_DATA_OE <= 1'b1;
            state       <= RTS;
          end else begin
            cnt <= cnt + 1'b1;
          end
          RTS: if (cnt == RTS_LAST) begin
            cnt        <= '0;
            bit_idx    <= '0;
            PS2_CLK_OE <= 1'b0;
            state      <= SEND;
          end else begin
            cnt <= cnt + 1'b1;
          end
          SEND: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx < 4'd8) begin
                PS2_DATA_OE <= ~tx_byte[bit_idx[2:0]];
              end else if (bit_idx == 4'd8) begin
                PS2_DATA_OE <= ~parity;
              end else begin
                PS2_DATA_OE <= 1'b0;
                state       <= ACK;
              end
            end
          end
          ACK: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              oErr  <= data_level;
              state <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            cnt <= cnt + 1'b1;
            if (clk_level && data_level) begin
              oDone <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            oBusy <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
